// File: rtl/ram_fifo_ctrl_if.sv
// Stream, occupancy and RAM-port bundle for ram_fifo_ctrl.
// slave is the controller side; master is the producer/consumer/RAM side.
interface ram_fifo_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 13
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH:0]   count;
    logic                  ram_en_a;
    logic [ADDR_WIDTH-1:0] ram_addr_a;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_en_b;
    logic [ADDR_WIDTH-1:0] ram_addr_b;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  in_valid, in_data, out_ready, ram_q,
        output in_ready, out_valid, out_data, count,
               ram_en_a, ram_addr_a, ram_data, ram_en_b, ram_addr_b
    );

    modport master (
        output in_valid, in_data, out_ready, ram_q,
        input  in_ready, out_valid, out_data, count,
               ram_en_a, ram_addr_a, ram_data, ram_en_b, ram_addr_b
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a simple dual-port sync-read RAM, with a 2-entry
// output stage that absorbs the read latency and gives 1 word/cycle under backpressure.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    ram_fifo_ctrl_if.slave   bus_io
);
    localparam int unsigned         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } occ_e;

    occ_e                  occ_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] slot0_q, slot1_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   ram_cnt_q, count_q;
    logic                  inflight_q;

    logic       flush, push, pop, rd, capture;
    logic [1:0] occ_n;
    logic [2:0] demand;

    assign flush = rst_i | clr_i;

    // in_ready depends only on registered count, never on out_ready.
    assign bus_io.in_ready = !flush && (count_q < DepthCnt);
    assign push            = bus_io.in_valid & bus_io.in_ready;
    assign pop             = out_valid_q & bus_io.out_ready;
    assign capture         = inflight_q;

    // Words the output stage must still hold after this edge, before any new read.
    assign occ_n  = occ_q;
    assign demand = {1'b0, occ_n} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd     = !flush && (ram_cnt_q != '0) && (demand < 3'd2);

    assign bus_io.ram_en_a   = push;
    assign bus_io.ram_addr_a = wr_ptr_q;
    assign bus_io.ram_data   = bus_io.in_data;
    assign bus_io.ram_en_b   = rd;
    assign bus_io.ram_addr_b = rd_ptr_q;
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.out_data   = slot0_q;
    assign bus_io.count      = count_q;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            if (rd)   rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            ram_cnt_q  <= ram_cnt_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(rd);
            count_q    <= count_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(pop);
            inflight_q <= rd;
        end
    end

    // Output stage: slot0_q is always the oldest held word.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            occ_q       <= StEmpty;
            out_valid_q <= 1'b0;
            slot0_q     <= '0;
            slot1_q     <= '0;
        end else begin
            unique case (occ_q)
                StEmpty: begin
                    if (capture) begin
                        slot0_q     <= bus_io.ram_q;
                        occ_q       <= StOne;
                        out_valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (capture && pop) begin
                        slot0_q <= bus_io.ram_q;
                    end else if (capture) begin
                        slot1_q <= bus_io.ram_q;
                        occ_q   <= StTwo;
                    end else if (pop) begin
                        occ_q       <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        slot0_q <= slot1_q;
                        if (capture) slot1_q <= bus_io.ram_q;
                        else         occ_q   <= StOne;
                    end
                end
                default: begin
                    occ_q       <= StEmpty;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with DEPTH=8: queue-based reference model checked every cycle,
// plus directed latency/fill/stream/backpressure/flush/reset scenarios.
module tb_ram_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (clr),
        .bus_io (bus)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_en_a) mem[bus.ram_addr_a] <= bus.ram_data;
        bus.ram_q <= bus.ram_en_b ? mem[bus.ram_addr_b] : '0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, occupancy and pointers as plain counters.
    logic [DW-1:0] m_q[$];
    int            m_cnt = 0;
    int            m_wr = 0;
    int            m_rd = 0;
    int            m_ram = 0;
    bit            chk_en = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            e_rdy, e_push, e_pop;

    always @(negedge clk) begin
        if (chk_en) begin
            e_rdy  = !rst && !clr && (m_cnt < DEPTH);
            e_push = bus.in_valid && e_rdy;
            e_pop  = bus.out_valid && bus.out_ready;
            chk("in_ready", bus.in_ready, e_rdy);
            chk("count", bus.count, m_cnt);
            chk("ram_en_a", bus.ram_en_a, e_push);
            if (e_push) begin
                chk("ram_addr_a", bus.ram_addr_a, m_wr);
                chk("ram_data", bus.ram_data, bus.in_data);
            end
            if (rst || clr) chk("flush_ram_en_b", bus.ram_en_b, 0);
            if (m_cnt == 0) begin
                chk("empty_out_valid", bus.out_valid, 0);
                chk("empty_ram_en_b", bus.ram_en_b, 0);
            end
            if (bus.ram_en_b) begin
                chk("rd_has_word", m_ram > 0, 1);
                chk("ram_addr_b", bus.ram_addr_b, m_rd);
            end
            if (bus.out_valid) begin
                chk("model_nonempty", m_q.size() > 0, 1);
                if (m_q.size() > 0) chk("out_order", bus.out_data, m_q[0]);
            end
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
            end
            if (rst || clr) begin
                m_q.delete();
                m_cnt = 0; m_wr = 0; m_rd = 0; m_ram = 0;
                prev_stall = 1'b0;
            end else begin
                if (e_push) begin
                    m_q.push_back(bus.in_data);
                    m_wr = (m_wr + 1) % DEPTH;
                    m_cnt++;
                    m_ram++;
                end
                if (e_pop && m_q.size() > 0) begin
                    void'(m_q.pop_front());
                    m_cnt--;
                end
                if (bus.ram_en_b) begin
                    m_rd = (m_rd + 1) % DEPTH;
                    m_ram--;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_test(input bit use_rst);
        string tag;
        bit    seen;
        tag = use_rst ? "rst" : "clr";
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h100 + i;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (4) step();
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_pre_rd_issue"}, bus.ram_en_b, 1);
        step();
        bus.out_ready = 1'b0;
        #1;
        chk({tag, "_pre_count"}, bus.count, 5);
        if (use_rst) begin
            rst = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hDEAD;
        end else begin
            clr = 1'b1;
        end
        #1;
        chk({tag, "_en_a_off"}, bus.ram_en_a, 0);
        chk({tag, "_en_b_off"}, bus.ram_en_b, 0);
        step();
        rst = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk({tag, "_post_valid"}, bus.out_valid, 0);
        chk({tag, "_post_count"}, bus.count, 0);
        chk({tag, "_post_ready"}, bus.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_no_stale"}, bus.out_valid, 0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        step();
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (bus.out_valid) seen = 1'b1;
            else step();
        end
        chk({tag, "_first_out_valid"}, bus.out_valid, 1);
        chk({tag, "_first_out_data"}, bus.out_data, 32'h77);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        chk({tag, "_drain_count"}, bus.count, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, got, w, rx, sent, bubbles;
        bit started;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_ram_en_a", bus.ram_en_a, 0);
        chk("rst_ram_en_b", bus.ram_en_b, 0);

        // Latency
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hA5A5_0001;
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("lat_c1_ram_en_b", bus.ram_en_b, 1);
        chk("lat_c1_count", bus.count, 1);
        chk("lat_c1_out_valid", bus.out_valid, 0);
        step();
        chk("lat_c2_count", bus.count, 1);
        chk("lat_c2_out_valid", bus.out_valid, 0);
        step();
        chk("lat_c3_out_valid", bus.out_valid, 1);
        chk("lat_c3_out_data", bus.out_data, 32'hA5A5_0001);
        chk("lat_c3_count", bus.count, 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        chk("lat_drain_count", bus.count, 0);

        // Fill
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = i;
            #1;
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        chk("fill_accepted", acc, 8);
        chk("fill_in_ready", bus.in_ready, 0);
        chk("fill_count", bus.count, 8);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            #1;
            if (bus.out_valid) begin
                chk("fill_order", bus.out_data, got + 1);
                got++;
            end
            step();
        end
        #1;
        chk("fill_got", got, 8);
        chk("fill_end_count", bus.count, 0);
        chk("fill_end_valid", bus.out_valid, 0);

        // Stream / wrap
        w = 0; rx = 0; bubbles = 0; started = 1'b0;
        for (int c = 0; c < 200 && rx < 40; c++) begin
            bus.in_valid = (w < 40);
            bus.in_data  = w;
            #1;
            if (bus.in_valid && bus.in_ready) w++;
            if (bus.out_valid) begin
                chk("stream_order", bus.out_data, rx);
                rx++;
                started = 1'b1;
            end else if (started) begin
                bubbles++;
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_sent", w, 40);
        chk("stream_rx", rx, 40);
        chk("stream_bubbles", bubbles, 0);

        // Random backpressure
        sent = 0; rx = 0;
        for (int c = 0; c < 8000 && rx < 500; c++) begin
            bus.in_valid  = (sent < 500) && ($urandom_range(0, 1) == 1);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) rx++;
            chk("bp_count_le_depth", bus.count <= DEPTH, 1);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_rx", rx, 500);
        step();

        flush_test(1'b0);
        flush_test(1'b1);

        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
